// File: rtl/ex_hazard_ctrl.sv
// Dual-issue execute hazard/forwarding controller: shadow E/M/W register metadata drives forward selects,
// load-use and intra-pair split stalls, and redirect flushes. All outputs are combinational (zero latency).
module ex_hazard_ctrl #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] RS1D_0,
   input  logic [REG_ADDR_W-1:0] RS2D_0,
   input  logic [REG_ADDR_W-1:0] RS1D_1,
   input  logic [REG_ADDR_W-1:0] RS2D_1,
   input  logic [REG_ADDR_W-1:0] RdD_0,
   input  logic [REG_ADDR_W-1:0] RdD_1,
   input  logic                  RegWriteD_0,
   input  logic                  RegWriteD_1,
   input  logic                  LoadD_0,
   input  logic                  LoadD_1,
   input  logic                  ValidD_0,
   input  logic                  ValidD_1,
   input  logic                  mux1E_0,
   input  logic                  mux1E_1,
   output logic [2:0]            ForwardAE_0,
   output logic [2:0]            ForwardBE_0,
   output logic [2:0]            ForwardAE_1,
   output logic [2:0]            ForwardBE_1,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic                  IssueE_0,
   output logic                  IssueE_1
);

   typedef struct packed {
      logic                  vld;
      logic                  rw;
      logic                  ld;
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
   } ex_t;

   typedef struct packed {
      logic                  vld;
      logic                  rw;
      logic [REG_ADDR_W-1:0] rd;
   } wb_t;

   typedef enum logic {ST_PAIR, ST_SPLIT} state_t;

   state_t     st_q, st_d;
   ex_t        e_q [2];
   ex_t        e_d [2];
   wb_t        m_q [2];
   wb_t        m_d [2];
   wb_t        w_q [2];
   wb_t        w_d [2];
   ex_t        d_in [2];
   logic [1:0] lu_d;
   logic       lu, dep, redir;
   logic [1:0] iss;
   logic       stall, flush;
   logic [2:0] fa [2];
   logic [2:0] fb [2];

   function automatic logic wb_hit(input wb_t s, input logic [REG_ADDR_W-1:0] rs);
      return s.vld && s.rw && (s.rd != '0) && (s.rd == rs);
   endfunction

   // Youngest producer wins: lane 1 is younger than lane 0 within a stage.
   function automatic logic [2:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                          input wb_t m0, input wb_t m1,
                                          input wb_t w0, input wb_t w1);
      if (rs == '0)            return 3'b000;
      else if (wb_hit(m1, rs)) return 3'b101;
      else if (wb_hit(m0, rs)) return 3'b010;
      else if (wb_hit(w1, rs)) return 3'b100;
      else if (wb_hit(w0, rs)) return 3'b001;
      else                     return 3'b000;
   endfunction

   always_comb begin
      d_in[0] = '{vld: ValidD_0, rw: RegWriteD_0, ld: LoadD_0, rd: RdD_0, rs1: RS1D_0, rs2: RS2D_0};
      d_in[1] = '{vld: ValidD_1, rw: RegWriteD_1, ld: LoadD_1, rd: RdD_1, rs1: RS1D_1, rs2: RS2D_1};
   end

   always_comb begin
      for (int l = 0; l < 2; l++) begin
         fa[l] = fwd_sel(e_q[l].rs1, m_q[0], m_q[1], w_q[0], w_q[1]);
         fb[l] = fwd_sel(e_q[l].rs2, m_q[0], m_q[1], w_q[0], w_q[1]);
      end
   end

   always_comb begin
      lu_d = '0;
      for (int k = 0; k < 2; k++) begin
         for (int l = 0; l < 2; l++) begin
            if (e_q[l].vld && e_q[l].ld && (e_q[l].rd != '0) && d_in[k].vld &&
                ((d_in[k].rs1 == e_q[l].rd) || (d_in[k].rs2 == e_q[l].rd)))
               lu_d[k] = 1'b1;
         end
      end
   end

   assign dep   = ValidD_0 & ValidD_1 & RegWriteD_0 & (RdD_0 != '0) &
                  ((RdD_0 == RS1D_1) | (RdD_0 == RS2D_1));
   assign redir = mux1E_0 | mux1E_1;
   // In SPLIT lane 0 has already left D, so only lane 1's sources can still collide with a load.
   assign lu    = (st_q == ST_SPLIT) ? lu_d[1] : (|lu_d);

   always_comb begin
      st_d  = st_q;
      stall = 1'b0;
      flush = 1'b0;
      iss   = 2'b00;
      if (redir) begin
         flush = 1'b1;
         st_d  = ST_PAIR;
      end else begin
         case (st_q)
            ST_PAIR: begin
               if (lu) begin
                  stall = 1'b1;
               end else if (dep) begin
                  iss   = 2'b01;
                  stall = 1'b1;
                  st_d  = ST_SPLIT;
               end else begin
                  iss = {ValidD_1, ValidD_0};
               end
            end
            ST_SPLIT: begin
               if (lu) begin
                  stall = 1'b1;
               end else begin
                  iss  = 2'b10;
                  st_d = ST_PAIR;
               end
            end
            default: st_d = ST_PAIR;
         endcase
      end
   end

   always_comb begin
      for (int l = 0; l < 2; l++) begin
         w_d[l] = m_q[l];
         m_d[l] = '{vld: e_q[l].vld, rw: e_q[l].rw, rd: e_q[l].rd};
         e_d[l] = (iss[l] && d_in[l].vld && !flush) ? d_in[l] : '0;
      end
      // A lane 0 redirect kills the younger lane 1 instruction sharing its E slot.
      if (mux1E_0)
         m_d[1] = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q <= ST_PAIR;
         for (int l = 0; l < 2; l++) begin
            e_q[l] <= '0;
            m_q[l] <= '0;
            w_q[l] <= '0;
         end
      end else begin
         st_q <= st_d;
         for (int l = 0; l < 2; l++) begin
            e_q[l] <= e_d[l];
            m_q[l] <= m_d[l];
            w_q[l] <= w_d[l];
         end
      end
   end

   assign ForwardAE_0 = fa[0];
   assign ForwardBE_0 = fb[0];
   assign ForwardAE_1 = fa[1];
   assign ForwardBE_1 = fb[1];
   // Gated so the decision outputs drop the moment reset asserts, regardless of D inputs.
   assign StallF      = rst_n & stall;
   assign StallD      = rst_n & stall;
   assign FlushD      = rst_n & flush;
   assign FlushE      = rst_n & flush;
   assign IssueE_0    = rst_n & iss[0];
   assign IssueE_1    = rst_n & iss[1];

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed scenarios then random traffic against a slot-based pipeline model.
module tb_ex_hazard_ctrl;

   typedef struct packed {
      logic       vld;
      logic       rw;
      logic       ld;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } instr_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] RS1D_0, RS2D_0, RS1D_1, RS2D_1, RdD_0, RdD_1;
   logic       RegWriteD_0, RegWriteD_1, LoadD_0, LoadD_1, ValidD_0, ValidD_1;
   logic       mux1E_0, mux1E_1;
   logic [2:0] ForwardAE_0, ForwardBE_0, ForwardAE_1, ForwardBE_1;
   logic       StallF, StallD, FlushD, FlushE, IssueE_0, IssueE_1;

   int total = 0;
   int bad   = 0;

   // Model state: the instruction occupying each lane of E, M, W, plus whether lane 0 of the D pair already left.
   instr_t me [2];
   instr_t mm [2];
   instr_t mw [2];
   bit     msplit;

   instr_t     cd0, cd1;
   bit         cmx0, cmx1;
   logic [2:0] xfa [2];
   logic [2:0] xfb [2];
   logic       xstall, xflush;
   logic [1:0] xiss;
   bit         xsplit_n;

   ex_hazard_ctrl #(.REG_ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .RS1D_0(RS1D_0), .RS2D_0(RS2D_0), .RS1D_1(RS1D_1), .RS2D_1(RS2D_1),
      .RdD_0(RdD_0), .RdD_1(RdD_1),
      .RegWriteD_0(RegWriteD_0), .RegWriteD_1(RegWriteD_1),
      .LoadD_0(LoadD_0), .LoadD_1(LoadD_1),
      .ValidD_0(ValidD_0), .ValidD_1(ValidD_1),
      .mux1E_0(mux1E_0), .mux1E_1(mux1E_1),
      .ForwardAE_0(ForwardAE_0), .ForwardBE_0(ForwardBE_0),
      .ForwardAE_1(ForwardAE_1), .ForwardBE_1(ForwardBE_1),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .IssueE_0(IssueE_0), .IssueE_1(IssueE_1)
   );

   always #5 clk = ~clk;

   function automatic instr_t mk(input logic v, input logic rw, input logic ld,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      instr_t r;
      r.vld = v; r.rw = rw; r.ld = ld; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
      return r;
   endfunction

   function automatic instr_t rnd();
      return mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
   endfunction

   // Producers listed youngest first; the first writer of rs wins.
   function automatic logic [2:0] fwd_ref(input logic [4:0] rs);
      instr_t     src  [4];
      logic [2:0] code [4];
      src[0] = mm[1]; code[0] = 3'b101;
      src[1] = mm[0]; code[1] = 3'b010;
      src[2] = mw[1]; code[2] = 3'b100;
      src[3] = mw[0]; code[3] = 3'b001;
      if (rs == 5'd0) return 3'b000;
      for (int i = 0; i < 4; i++)
         if (src[i].vld && src[i].rw && src[i].rd != 5'd0 && src[i].rd == rs) return code[i];
      return 3'b000;
   endfunction

   function automatic bit reads_load(input instr_t d);
      for (int l = 0; l < 2; l++)
         if (me[l].vld && me[l].ld && me[l].rd != 5'd0 && d.vld &&
             (d.rs1 == me[l].rd || d.rs2 == me[l].rd)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int l = 0; l < 2; l++) begin
         me[l] = '0; mm[l] = '0; mw[l] = '0;
      end
      msplit = 1'b0;
   endtask

   task automatic model_eval();
      bit redirect, dep, hz;
      redirect = cmx0 | cmx1;
      dep = cd0.vld && cd1.vld && cd0.rw && cd0.rd != 5'd0 && (cd0.rd == cd1.rs1 || cd0.rd == cd1.rs2);
      hz  = msplit ? reads_load(cd1) : (reads_load(cd0) || reads_load(cd1));
      for (int l = 0; l < 2; l++) begin
         xfa[l] = fwd_ref(me[l].rs1);
         xfb[l] = fwd_ref(me[l].rs2);
      end
      xstall = 1'b0; xflush = 1'b0; xiss = 2'b00; xsplit_n = msplit;
      if (redirect) begin
         xflush = 1'b1; xsplit_n = 1'b0;
      end else if (hz) begin
         xstall = 1'b1;
      end else if (msplit) begin
         xiss = 2'b10; xsplit_n = 1'b0;
      end else if (dep) begin
         xiss = 2'b01; xstall = 1'b1; xsplit_n = 1'b1;
      end else begin
         xiss = {cd1.vld, cd0.vld};
      end
   endtask

   task automatic model_advance();
      mw = mm;
      mm = me;
      if (cmx0) mm[1] = '0;
      me[0] = (xiss[0] && cd0.vld) ? cd0 : '0;
      me[1] = (xiss[1] && cd1.vld) ? cd1 : '0;
      msplit = xsplit_n;
   endtask

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_FA0"}, ForwardAE_0, 3'b000);
      chk({tag, "_FB0"}, ForwardBE_0, 3'b000);
      chk({tag, "_FA1"}, ForwardAE_1, 3'b000);
      chk({tag, "_FB1"}, ForwardBE_1, 3'b000);
      chk({tag, "_ctl"}, {1'b0, StallF, StallD}, 3'b000);
      chk({tag, "_flush"}, {1'b0, FlushD, FlushE}, 3'b000);
      chk({tag, "_issue"}, {1'b0, IssueE_1, IssueE_0}, 3'b000);
   endtask

   task automatic apply(input instr_t d0, input instr_t d1, input bit x0, input bit x1);
      ValidD_0 = d0.vld; RegWriteD_0 = d0.rw; LoadD_0 = d0.ld; RdD_0 = d0.rd; RS1D_0 = d0.rs1; RS2D_0 = d0.rs2;
      ValidD_1 = d1.vld; RegWriteD_1 = d1.rw; LoadD_1 = d1.ld; RdD_1 = d1.rd; RS1D_1 = d1.rs1; RS2D_1 = d1.rs2;
      mux1E_0 = x0; mux1E_1 = x1;
      cd0 = d0; cd1 = d1; cmx0 = x0; cmx1 = x1;
      #1;
      model_eval();
      chk("FA0", ForwardAE_0, xfa[0]);
      chk("FB0", ForwardBE_0, xfb[0]);
      chk("FA1", ForwardAE_1, xfa[1]);
      chk("FB1", ForwardBE_1, xfb[1]);
      chk("StallF", {2'b00, StallF}, {2'b00, xstall});
      chk("StallD", {2'b00, StallD}, {2'b00, xstall});
      chk("FlushD", {2'b00, FlushD}, {2'b00, xflush});
      chk("FlushE", {2'b00, FlushE}, {2'b00, xflush});
      chk("IssueE_0", {2'b00, IssueE_0}, {2'b00, xiss[0]});
      chk("IssueE_1", {2'b00, IssueE_1}, {2'b00, xiss[1]});
   endtask

   task automatic tick();
      @(posedge clk);
      model_advance();
      @(negedge clk);
   endtask

   initial begin
      instr_t nop;
      nop = '0;
      rst_n = 1'b0;
      ValidD_0 = 0; RegWriteD_0 = 0; LoadD_0 = 0; RdD_0 = 0; RS1D_0 = 0; RS2D_0 = 0;
      ValidD_1 = 0; RegWriteD_1 = 0; LoadD_1 = 0; RdD_1 = 0; RS1D_1 = 0; RS2D_1 = 0;
      mux1E_0 = 0; mux1E_1 = 0;
      model_reset();
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // addi x5 in lane 0, then add x6,x5,x5 in lane 1: M lane 0 then W lane 0 forwarding
      apply(mk(1, 1, 0, 5, 0, 0), nop, 0, 0); tick();
      apply(nop, mk(1, 1, 0, 6, 5, 5), 0, 0); tick();
      apply(mk(1, 0, 0, 11, 5, 0), nop, 0, 0);
      chk("fwd_M0_A1", ForwardAE_1, 3'b010);
      chk("fwd_M0_B1", ForwardBE_1, 3'b010);
      tick();
      apply(nop, nop, 0, 0);
      chk("fwd_W0_A0", ForwardAE_0, 3'b001);
      tick();

      // both lanes write x7: lane 1 wins; x0 never forwards
      apply(mk(1, 1, 0, 7, 0, 0), mk(1, 1, 0, 7, 0, 0), 0, 0); tick();
      apply(mk(1, 0, 0, 0, 7, 0), nop, 0, 0); tick();
      apply(nop, nop, 0, 0);
      chk("fwd_M1_wins", ForwardAE_0, 3'b101);
      tick();
      apply(mk(1, 1, 0, 0, 0, 0), nop, 0, 0); tick();
      apply(mk(1, 0, 0, 0, 0, 0), nop, 0, 0); tick();
      apply(nop, nop, 0, 0);
      chk("fwd_x0", ForwardAE_0, 3'b000);
      tick();

      // lw x8 then a lane 1 reader of x8: one-cycle load-use stall
      apply(mk(1, 1, 1, 8, 0, 0), nop, 0, 0); tick();
      apply(nop, mk(1, 1, 0, 16, 8, 0), 0, 0);
      chk("lu_stall", {1'b0, StallF, StallD}, 3'b011);
      chk("lu_issue", {1'b0, IssueE_1, IssueE_0}, 3'b000);
      tick();
      apply(nop, mk(1, 1, 0, 16, 8, 0), 0, 0);
      chk("lu_release", {StallF, IssueE_1, IssueE_0}, 3'b010);
      tick();
      apply(nop, nop, 0, 0); tick();

      // add x9 / sub x10,x9: split issue
      apply(mk(1, 1, 0, 9, 1, 2), mk(1, 1, 0, 10, 9, 3), 0, 0);
      chk("split_c1", {StallF, IssueE_1, IssueE_0}, 3'b101);
      tick();
      apply(mk(1, 1, 0, 9, 1, 2), mk(1, 1, 0, 10, 9, 3), 0, 0);
      chk("split_c2", {StallF, IssueE_1, IssueE_0}, 3'b010);
      tick();
      apply(nop, nop, 0, 0);
      chk("split_fwd", ForwardAE_1, 3'b010);
      tick();

      // lane 0 redirect with lane 1 valid in E and a dependent pair in D
      apply(mk(1, 1, 0, 13, 0, 0), mk(1, 1, 0, 12, 0, 0), 0, 0); tick();
      apply(mk(1, 1, 0, 20, 0, 0), mk(1, 1, 0, 21, 20, 0), 1, 0);
      chk("redir_flush", {1'b0, FlushD, FlushE}, 3'b011);
      chk("redir_ctl", {StallF, IssueE_1, IssueE_0}, 3'b000);
      tick();
      apply(mk(1, 1, 0, 14, 12, 13), mk(1, 1, 0, 22, 14, 0), 0, 0);
      chk("redir_pair", {StallF, IssueE_1, IssueE_0}, 3'b101);
      tick();
      apply(mk(1, 1, 0, 14, 12, 13), mk(1, 1, 0, 22, 14, 0), 0, 0);
      chk("redir_kill_l1", ForwardAE_0, 3'b000);
      chk("redir_keep_l0", ForwardBE_0, 3'b001);
      tick();

      // load-dependent pair: SPLIT with stall high, then async reset
      apply(mk(1, 1, 1, 15, 0, 0), mk(1, 1, 0, 23, 15, 0), 0, 0); tick();
      apply(mk(1, 1, 1, 15, 0, 0), mk(1, 1, 0, 23, 15, 0), 0, 0);
      chk("split_lu_stall", {StallF, IssueE_1, IssueE_0}, 3'b100);
      rst_n = 1'b0;
      #2;
      chk_all_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      apply(mk(1, 1, 1, 15, 0, 0), mk(1, 1, 0, 23, 15, 0), 0, 0);
      chk("post_rst_pair", {StallF, IssueE_1, IssueE_0}, 3'b101);
      tick();

      for (int i = 0; i < 600; i++) begin
         apply(rnd(), rnd(), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
